// File: rtl/keypad_scanner_db.sv
// keypad_scanner_db: one-cold column scanner with press/release debounce,
// optional auto-repeat and a single-entry valid/ready event register.
// Ports: clk, nRst (async, active low), enable (gates tick and FSM);
//   read_row (async row sense) in, scan_col (one-cold drive) out;
//   key_valid/key_ready handshake carrying key_code, key_row, key_col
//   and key_repeat; key_held (key accepted, not yet released);
//   overrun (one-cycle pulse when an event is dropped).
module keypad_scanner_db #(
  parameter  int ROWS         = 4,
  parameter  int COLS         = 4,
  parameter  int SCAN_DIV     = 100000,
  parameter  int DEBOUNCE     = 4,
  parameter  int REPEAT_TICKS = 0,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 enable,
  input  logic [ROWS-1:0]      read_row,
  output logic [COLS-1:0]      scan_col,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [ROWS+COLS-1:0] key_code,
  output logic [RW-1:0]        key_row,
  output logic [CW-1:0]        key_col,
  output logic                 key_repeat,
  output logic                 key_held,
  output logic                 overrun
);

  localparam int TW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int RPW =
    (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB,
    S_PRESSED,
    S_RELEASE
  } state_t;

  state_t               r_state, w_state_n;
  logic [ROWS-1:0]      r_sync1, r_sync2;
  logic [ROWS-1:0]      r_cap_row, w_cap_n, w_evt_row;
  logic [TW-1:0]        r_cnt;
  logic [CW-1:0]        r_ptr, w_ptr_n, w_ptr_inc;
  logic [COLS-1:0]      r_scan;
  logic [DBW-1:0]       r_deb, w_deb_n;
  logic [DBW-1:0]       r_rel, w_rel_n;
  logic [RPW-1:0]       r_rep, w_rep_n;
  logic                 w_tick, w_onehot, w_xfer;
  logic                 w_emit, w_emit_rep;
  logic [RW-1:0]        w_evt_idx;
  logic                 r_valid, r_repeat, r_ovr;
  logic [ROWS+COLS-1:0] r_code;
  logic [RW-1:0]        r_row;
  logic [CW-1:0]        r_col;

  assign w_tick =
    enable && (r_cnt == TW'(SCAN_DIV - 1));
  assign w_onehot = (r_sync2 != '0) &&
    ((r_sync2 & (r_sync2 - 1'b1)) == '0);
  assign w_ptr_inc = (r_ptr == CW'(COLS - 1)) ?
    '0 : r_ptr + 1'b1;
  assign w_xfer = r_valid && key_ready;

  always_comb begin
    w_state_n  = r_state;
    w_ptr_n    = r_ptr;
    w_cap_n    = r_cap_row;
    w_deb_n    = r_deb;
    w_rel_n    = r_rel;
    w_rep_n    = r_rep;
    w_emit     = 1'b0;
    w_emit_rep = 1'b0;
    w_evt_row  = r_cap_row;
    if (w_tick) begin
      unique case (r_state)
        S_SCAN: begin
          // All-ones drive means no column was driven yet, so the
          // rows carry no information on this tick.
          if (!(&r_scan)) begin
            if (w_onehot) begin
              w_cap_n = r_sync2;
              w_deb_n = DBW'(1);
              if (DEBOUNCE == 1) begin
                w_emit    = 1'b1;
                w_evt_row = r_sync2;
                w_rel_n   = '0;
                w_rep_n   = '0;
                w_state_n = S_PRESSED;
              end else begin
                w_state_n = S_DEB;
              end
            end else begin
              w_ptr_n = w_ptr_inc;
            end
          end
        end
        S_DEB: begin
          if (r_sync2 == r_cap_row) begin
            w_deb_n = r_deb + 1'b1;
            if (w_deb_n == DBW'(DEBOUNCE)) begin
              w_emit    = 1'b1;
              w_rel_n   = '0;
              w_rep_n   = '0;
              w_state_n = S_PRESSED;
            end
          end else begin
            w_state_n = S_SCAN;
          end
        end
        S_PRESSED: begin
          w_rel_n = (r_sync2 == '0) ?
            r_rel + 1'b1 : '0;
          if (w_rel_n == DBW'(DEBOUNCE)) begin
            w_state_n = S_RELEASE;
          end
          if (REPEAT_TICKS > 0 &&
              r_sync2 == r_cap_row) begin
            w_rep_n = r_rep + 1'b1;
            if (w_rep_n == RPW'(REPEAT_TICKS)) begin
              w_emit     = 1'b1;
              w_emit_rep = 1'b1;
              w_rep_n    = '0;
            end
          end
        end
        S_RELEASE: begin
          w_ptr_n   = w_ptr_inc;
          w_state_n = S_SCAN;
        end
        default: w_state_n = S_SCAN;
      endcase
    end
  end

  always_comb begin
    w_evt_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (w_evt_row[i]) w_evt_idx = RW'(i);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= read_row;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= S_SCAN;
      r_ptr     <= '0;
      r_scan    <= '1;
      r_cap_row <= '0;
      r_deb     <= '0;
      r_rel     <= '0;
      r_rep     <= '0;
    end else if (w_tick) begin
      r_state   <= w_state_n;
      r_ptr     <= w_ptr_n;
      r_scan    <= ~(COLS'(1) << w_ptr_n);
      r_cap_row <= w_cap_n;
      r_deb     <= w_deb_n;
      r_rel     <= w_rel_n;
      r_rep     <= w_rep_n;
    end
  end

  // A new event loads when the register is empty or being drained
  // this cycle; otherwise it is dropped and flagged.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_valid  <= 1'b0;
      r_code   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_repeat <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_emit && (!r_valid || key_ready)) begin
        r_valid  <= 1'b1;
        r_code   <= {w_evt_row, COLS'(1) << r_ptr};
        r_row    <= w_evt_idx;
        r_col    <= r_ptr;
        r_repeat <= w_emit_rep;
      end else if (w_emit) begin
        r_ovr <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign scan_col   = r_scan;
  assign key_valid  = r_valid;
  assign key_code   = r_code;
  assign key_row    = r_row;
  assign key_col    = r_col;
  assign key_repeat = r_repeat;
  assign key_held   = (r_state == S_PRESSED);
  assign overrun    = r_ovr;

endmodule

// File: doc/keypad_scanner_db.md
Name: keypad_scanner_db

Overview:
- Parametrised keypad front end that replaces the fixed 4x4 scanner.
- Drives one-cold column scan at a divided tick rate and synchronises row sense inputs.
- Debounces both press and release, and can optionally auto-repeat a held key.
- Delivers one key event per press (plus repeats) to the multi-tap FSM through a single-entry valid/ready holding register, with overrun detection.

Parameters:
- ROWS, 4, number of row sense lines
- COLS, 4, number of column drive lines
- SCAN_DIV, 100000, clk cycles per scan tick (>=2)
- DEBOUNCE, 4, consecutive stable ticks required to accept a press or release (>=1)
- REPEAT_TICKS, 0, held ticks between auto-repeat events; 0 disables repeat

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- enable  in  1  gates the tick counter and scan FSM
- read_row  in  ROWS  row sense, active-high, asynchronous to clk
- scan_col  out  COLS  column drive, active-low one-cold; all ones = idle
- key_valid  out  1  event held in output register
- key_ready  in  1  consumer accepts event when key_valid & key_ready
- key_code  out  ROWS+COLS  {row one-hot, column one-hot (active-high)}
- key_row  out  RW  row index; RW = max(1, clog2(ROWS))
- key_col  out  CW  column index; CW = max(1, clog2(COLS))
- key_repeat  out  1  event is an auto-repeat, not the initial press
- key_held  out  1  FSM in PRESSED state
- overrun  out  1  one-cycle pulse when an event is dropped

Behaviour:
Reset values:
- scan_col = all ones; key_valid, key_repeat, key_held, overrun = 0; key_code, key_row, key_col = 0.
- State = SCAN; column pointer = 0; tick counter = 0; synchroniser = 0.

Synchroniser and tick:
- read_row passes through a 2-FF synchroniser; "row" below means the synchronised value.
- Tick counter counts 0..SCAN_DIV-1; tick = (count == SCAN_DIV-1), after which the counter wraps to 0.
- enable=0: counter, FSM and scan_col are frozen. The output handshake still operates.

FSM (evaluated only on tick):
- SCAN:
  - scan_col = ~(1<<ptr).
  - If row is exactly one-hot: capture row and ptr, deb=1. If DEBOUNCE==1, emit the event and go to PRESSED; otherwise go to DEBOUNCE.
  - If row is zero or multi-hot: ptr advances and wraps COLS-1 -> 0. A multi-hot row is ignored.
  - First tick after reset drives column 0 (scan_col changes from all ones).
- DEBOUNCE:
  - Column is held.
  - Row == captured row: deb++. At deb==DEBOUNCE, emit the event and go to PRESSED with rep=0.
  - Row differs: return to SCAN without advancing ptr. No event.
- PRESSED:
  - key_held=1; column is held.
  - Row == 0: rel++. Otherwise rel=0.
  - At rel==DEBOUNCE: go to RELEASE.
  - If REPEAT_TICKS>0 and row == captured row: rep++. At rep==REPEAT_TICKS, emit a repeat event and set rep=0.
- RELEASE:
  - Single tick state. Advance ptr with wrap, then go to SCAN.

Output handshake:
- An emitted event is written to the output register on the clk edge ending the tick cycle, so key_valid rises 1 cycle after the tick.
- Transfer occurs on key_valid & key_ready. key_valid falls the next cycle unless a new event loads in the same cycle.
- Event while key_valid=1 and key_ready=0: the event is dropped, overrun pulses 1 cycle, and the held data is unchanged.
- Event in the same cycle as a transfer: the new event loads, key_valid stays 1, and overrun=0.
- key_code row field = captured one-hot row; column field = 1<<ptr.
- Data is stable while key_valid=1 and not yet accepted.
- Reset mid-operation: all state returns to reset values immediately, and any pending event is lost.

Test Plan:
(ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, REPEAT_TICKS=0 unless stated)
- Reset then idle, enable=1 -> scan_col: 1111 -> 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing every 4 cycles. No key_valid.
- Hold read_row=0010 while column 2 is driven, key_ready=1 -> one event: key_code=8'b0010_0100, key_row=1, key_col=2, key_repeat=0. key_held=1 until 3 zero ticks after release, then scan resumes at column 3.
- Row bounce 0010 / 0000 on alternate ticks during DEBOUNCE -> no event, and the FSM returns to SCAN on the same column.
- Row 0011 (multi-hot) held -> no event, and the scan keeps advancing.
- key_ready=0, two presses of different keys -> first event is held unchanged, overrun pulses once at the second press. Then key_ready=1 -> one transfer, key_valid drops.
- REPEAT_TICKS=5, key held for 20 ticks with key_ready=1 -> initial event plus 3 repeat events, each with key_repeat=1. Asserting nRst=0 mid-hold -> all outputs are 0 and scan_col=1111 immediately.
